// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: instruction size, default vectors and the
// next-PC source encoding used by pc_unit.
package mips_pkg;

  localparam int unsigned INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_J    = 3'd2,
    PC_JR   = 3'd3,
    PC_EXC  = 3'd4,
    PC_HOLD = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: pc+INC, branch target, J-format target
// and the JR misalignment flag.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC   = INSTR_BYTES
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [15:0]      branch_off_i,
  input  logic [25:0]      jump_tgt_i,
  input  logic [1:0]       jr_low_i,
  output logic [WIDTH-1:0] pc_plus_inc_o,
  output logic [WIDTH-1:0] br_target_o,
  output logic [WIDTH-1:0] j_target_o,
  output logic             jr_misalign_o
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] br_off_ext_s;

  assign pc_plus_inc_o = pc_i + INC_W;
  assign br_off_ext_s  = {{(WIDTH-18){branch_off_i[15]}}, branch_off_i, 2'b00};
  assign br_target_o   = pc_plus_inc_o + br_off_ext_s;
  assign jr_misalign_o = (jr_low_i != 2'b00);

  // At the minimum width the J target has no region bits to carry over.
  if (WIDTH > 28) begin : g_region
    assign j_target_o = {pc_plus_inc_o[WIDTH-1:28], jump_tgt_i, 2'b00};
  end else begin : g_noregion
    assign j_target_o = {jump_tgt_i, 2'b00};
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with branch/jump/JR/exception select, EPC capture
// and misaligned-JR detection. Define PC_UNIT_DELAY_SLOT_EN for branch delay slots.
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned INC          = INSTR_BYTES,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_off,
  input  logic             jump,
  input  logic [25:0]      jump_tgt,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
  logic             addr_err_q;
  logic [WIDTH-1:0] br_target_s, j_target_s, redir_s;
  logic             jr_misalign_s, addr_err_s;
  pc_src_e          pc_src_s;
`ifdef PC_UNIT_DELAY_SLOT_EN
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] ptgt_q, ptgt_d;
`endif

  pc_target_calc #(.WIDTH(WIDTH), .INC(INC)) u_calc (
    .pc_i          (pc_q),
    .branch_off_i  (branch_off),
    .jump_tgt_i    (jump_tgt),
    .jr_low_i      (jr_addr[1:0]),
    .pc_plus_inc_o (pc_plus_inc),
    .br_target_o   (br_target_s),
    .j_target_o    (j_target_s),
    .jr_misalign_o (jr_misalign_s)
  );

  assign addr_err_s = jump_reg & jr_misalign_s;

  // Priority select of the next-PC source.
  always_comb begin
    pc_src_s = PC_SEQ;
    if (exception || addr_err_s) begin
      pc_src_s = PC_EXC;
    end else if (stall) begin
      pc_src_s = PC_HOLD;
    end else if (jump_reg) begin
      pc_src_s = PC_JR;
    end else if (jump) begin
      pc_src_s = PC_J;
    end else if (branch_taken) begin
      pc_src_s = PC_BR;
    end else begin
      pc_src_s = PC_SEQ;
    end
  end

  // Redirect target for the selected source.
  always_comb begin
    redir_s = pc_plus_inc;
    case (pc_src_s)
      PC_JR:   redir_s = jr_addr;
      PC_J:    redir_s = j_target_s;
      PC_BR:   redir_s = br_target_s;
      default: redir_s = pc_plus_inc;
    endcase
  end

  // Next-state for PC, EPC and the delay-slot pending target.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
`ifdef PC_UNIT_DELAY_SLOT_EN
    pend_d = pend_q;
    ptgt_d = ptgt_q;
`endif
    case (pc_src_s)
      PC_EXC: begin
        pc_d  = EXC_W;
        epc_d = pc_q;
`ifdef PC_UNIT_DELAY_SLOT_EN
        pend_d = 1'b0;
`endif
      end
      PC_HOLD: pc_d = pc_q;
      PC_SEQ, PC_JR, PC_J, PC_BR: begin
`ifdef PC_UNIT_DELAY_SLOT_EN
        // A request made while a redirect is pending sits in the delay slot and is dropped.
        if (pend_q) begin
          pc_d   = ptgt_q;
          pend_d = 1'b0;
        end else if (pc_src_s != PC_SEQ) begin
          pc_d   = pc_plus_inc;
          ptgt_d = redir_s;
          pend_d = 1'b1;
        end else begin
          pc_d = pc_plus_inc;
        end
`else
        pc_d = redir_s;
`endif
      end
      default: pc_d = pc_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RST_W;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
      pend_q     <= 1'b0;
      ptgt_q     <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_s;
`ifdef PC_UNIT_DELAY_SLOT_EN
      pend_q     <= pend_d;
      ptgt_q     <= ptgt_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: reference model plus directed and random stimulus.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jump_reg, exception;
  logic [15:0] branch_off;
  logic [25:0] jump_tgt;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus_inc, epc;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference state
  logic [31:0] m_pc, m_epc, m_ptgt;
  logic        m_err, m_pend;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_off(branch_off), .jump(jump), .jump_tgt(jump_tgt), .jump_reg(jump_reg),
    .jr_addr(jr_addr), .exception(exception), .pc(pc), .pc_plus_inc(pc_plus_inc),
    .epc(epc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: what the PC must be after each edge, from the stated rules.
  always @(posedge clk) begin
    logic [31:0] inc, tgt;
    logic        mis, redirect;
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_err = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0;
    end else begin
      inc      = m_pc + 32'd4;
      mis      = jump_reg && (jr_addr[1:0] != 2'b00);
      m_err    = mis;
      redirect = jump_reg || jump || branch_taken;
      if (jump_reg)   tgt = jr_addr;
      else if (jump)  tgt = {inc[31:28], jump_tgt, 2'b00};
      else            tgt = inc + {{14{branch_off[15]}}, branch_off, 2'b00};
      if (exception || mis) begin
        m_epc = m_pc; m_pc = 32'h180; m_pend = 1'b0;
      end else if (!stall) begin
`ifdef PC_UNIT_DELAY_SLOT_EN
        if (m_pend) begin
          m_pc = m_ptgt; m_pend = 1'b0;
        end else if (redirect) begin
          m_ptgt = tgt; m_pend = 1'b1; m_pc = inc;
        end else begin
          m_pc = inc;
        end
`else
        m_pc = redirect ? tgt : inc;
`endif
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
      check("epc", epc, m_epc);
      check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic exc, input logic jr,
                     input logic [31:0] ja, input logic j, input logic [25:0] jt,
                     input logic br, input logic [15:0] off);
    reset = rst; stall = st; exception = exc; jump_reg = jr; jr_addr = ja;
    jump = j; jump_tgt = jt; branch_taken = br; branch_off = off;
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0; exception = 1'b0; jump_reg = 1'b0;
    jump = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic free1();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
  endtask

  task automatic jr_to(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, a, 1'b0, 26'h0, 1'b0, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; exception = 1'b0; jump_reg = 1'b0; jr_addr = 32'h0;
    jump = 1'b0; jump_tgt = 26'h0; branch_taken = 1'b0; branch_off = 16'h0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h3, 1'b1, 26'h5, 1'b1, 16'h7);
    chk_en = 1'b1;
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_epc", epc, 32'h0);
    check("lit_reset_err", {31'd0, addr_err}, 32'h0);
    free1(); check("lit_seq1", pc, 32'h4);
    free1(); check("lit_seq2", pc, 32'h8);
    free1(); check("lit_seq3", pc, 32'hC);
`ifndef PC_UNIT_DELAY_SLOT_EN
    jr_to(32'h100); check("lit_jr100", pc, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFC);
    check("lit_br_back", pc, 32'hF4);
    jr_to(32'h100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0010);
    check("lit_br_fwd", pc, 32'h144);
    jr_to(32'h1000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0040, 1'b1, 16'h0010);
    check("lit_jump_wins", pc, 32'h1000_0100);
    jr_to(32'h200);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h123, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h123, 1'b0, 16'h0);
    check("lit_stall_hold", pc, 32'h200);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    check("lit_exc_pc", pc, 32'h180);
    check("lit_exc_epc", epc, 32'h200);
    jr_to(32'h300);
    jr_to(32'h402);
    check("lit_aerr_pc", pc, 32'h180);
    check("lit_aerr_epc", epc, 32'h300);
    check("lit_aerr_hi", {31'd0, addr_err}, 32'h1);
    free1();
    check("lit_aerr_lo", {31'd0, addr_err}, 32'h0);
    jr_to(32'h300);
    jr_to(32'h400);
    check("lit_jr_ok_pc", pc, 32'h400);
    check("lit_jr_ok_err", {31'd0, addr_err}, 32'h0);
    jr_to(32'hFFFF_FFFC);
    free1(); check("lit_wrap", pc, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    check("lit_reset_in_stall", pc, 32'h0);
`else
    jr_to(32'h100); check("lit_ds_slot", pc, 32'h10);
    free1(); check("lit_ds_jr", pc, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h003F);
    check("lit_ds_br_slot", pc, 32'h104);
    free1(); check("lit_ds_br_tgt", pc, 32'h200);
    jr_to(32'h500); check("lit_ds_pend", pc, 32'h204);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    check("lit_ds_reset", pc, 32'h0);
    free1(); check("lit_ds_cleared", pc, 32'h4);
`endif
    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 7) == 0, a, $urandom_range(0, 5) == 0, 26'($urandom),
          $urandom_range(0, 3) == 0, 16'($urandom));
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
